// File: rtl/spec_pkg.sv
// Shared definitions for the FFT front end: the default data-RAM geometry
// (also used by the FFT engine), the loader state encoding, and a
// bit-reverse helper for the default address width.
package spec_pkg;

  localparam int RAM_WIDTH     = 18;
  localparam int RAM_ADDR_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2
  } loader_state_e;

  // Bit reversal at the default address width: result[i] = v[W-1-i].
  function automatic logic [RAM_ADDR_BITS-1:0] bit_reverse(
    input logic [RAM_ADDR_BITS-1:0] v
  );
    logic [RAM_ADDR_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < RAM_ADDR_BITS; i++) begin
      r[i] = v[RAM_ADDR_BITS-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_sample_loader_bitrev.sv
// Combinational bit reversal of a WIDTH-bit value; reusable by the FFT
// address generator.
//   val_i  in   WIDTH  value to reverse
//   rev_o  out  WIDTH  rev_o[i] = val_i[WIDTH-1-i]
module fft_sample_loader_bitrev #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] rev_o
);

  always_comb begin
    rev_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rev_o[i] = val_i[WIDTH-1-i];
    end
  end

endmodule

// File: rtl/fft_sample_loader.sv
// Collects one frame of 2**RAM_ADDR_BITS ADC samples and writes them,
// sign-extended, into the real FFT RAM at bit-reversed addresses (zero into
// the imaginary RAM). Holds the frame until the FFT engine reports done.
//   Clk           in   1               system clock
//   reset         in   1               synchronous active-high reset
//   enable        in   1               arm capture (level)
//   sample_in     in   SAMPLE_WIDTH    signed ADC sample
//   sample_valid  in   1               sample strobe
//   fft_done      in   1               FFT finished, RAMs may be refilled
//   addr          out  RAM_ADDR_BITS   write address (both RAMs)
//   din_re        out  RAM_WIDTH       real RAM data
//   din_im        out  RAM_WIDTH       imag RAM data, always zero
//   write_enable  out  1               write strobe (both RAMs)
//   frame_ready   out  1               full frame resident
//   overrun       out  1               sticky, a sample was dropped
//   sample_count  out  RAM_ADDR_BITS+1 samples written this frame
//
// state | meaning
// IDLE  | not armed, strobes ignored
// FILL  | capturing; a strobe is latched, written the next cycle
// READY | frame complete, waiting for fft_done
module fft_sample_loader #(
  parameter int RAM_WIDTH     = spec_pkg::RAM_WIDTH,
  parameter int RAM_ADDR_BITS = spec_pkg::RAM_ADDR_BITS,
  parameter int SAMPLE_WIDTH  = 12
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [SAMPLE_WIDTH-1:0]  sample_in,
  input  logic                     sample_valid,
  input  logic                     fft_done,
  output logic [RAM_ADDR_BITS-1:0] addr,
  output logic [RAM_WIDTH-1:0]     din_re,
  output logic [RAM_WIDTH-1:0]     din_im,
  output logic                     write_enable,
  output logic                     frame_ready,
  output logic                     overrun,
  output logic [RAM_ADDR_BITS:0]   sample_count
);

  import spec_pkg::*;

  localparam int CW = RAM_ADDR_BITS + 1;
  localparam logic [CW-1:0] FRAME_LEN = {1'b1, {RAM_ADDR_BITS{1'b0}}};

  if (SAMPLE_WIDTH > RAM_WIDTH) begin : g_width_check
    $error("SAMPLE_WIDTH must not exceed RAM_WIDTH");
  end

  loader_state_e            state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [RAM_WIDTH-1:0]     din_re_q, din_re_d;
  logic                     we_q, we_d;
  logic                     overrun_q, overrun_d;
  logic [RAM_ADDR_BITS-1:0] addr_rev;

  // cnt_q has already advanced past the sample being written, so its
  // reversal is the address of the next sample.
  fft_sample_loader_bitrev #(
    .WIDTH (RAM_ADDR_BITS)
  ) u_bitrev (
    .val_i (cnt_q[RAM_ADDR_BITS-1:0]),
    .rev_o (addr_rev)
  );

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      din_re_q  <= '0;
      we_q      <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      din_re_q  <= din_re_d;
      we_q      <= we_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    din_re_d  = din_re_q;
    we_d      = 1'b0;
    overrun_d = overrun_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_FILL;
          cnt_d   = '0;
          addr_d  = '0;
        end
      end

      ST_FILL: begin
        if (we_q) begin
          // Write cycle: a strobe here arrives too soon and is lost. The
          // address moves on only after the write so the RAM sees it stable.
          addr_d = addr_rev;
          if (sample_valid) begin
            overrun_d = 1'b1;
          end
          if (cnt_q == FRAME_LEN) begin
            state_d = ST_READY;
          end
        end else if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          addr_d  = '0;
        end else if (sample_valid) begin
          we_d     = 1'b1;
          din_re_d = RAM_WIDTH'($signed(sample_in));
          cnt_d    = cnt_q + CW'(1);
        end
      end

      ST_READY: begin
        if (sample_valid) begin
          overrun_d = 1'b1;
        end
        if (fft_done) begin
          cnt_d   = '0;
          addr_d  = '0;
          state_d = enable ? ST_FILL : ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        addr_d  = '0;
      end
    endcase
  end

  assign addr         = addr_q;
  assign din_re       = din_re_q;
  assign din_im       = '0;
  assign write_enable = we_q;
  assign frame_ready  = (state_q == ST_READY);
  assign overrun      = overrun_q;
  assign sample_count = cnt_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed bench for fft_sample_loader with default parameters.
module tb_fft_sample_loader;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        fft_done = 1'b0;
  logic [9:0]  addr;
  logic [17:0] din_re;
  logic [17:0] din_im;
  logic        write_enable;
  logic        frame_ready;
  logic        overrun;
  logic [10:0] sample_count;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [9:0]  a;
    logic [17:0] re;
    logic [17:0] im;
  } wr_t;
  wr_t wr_q[$];

  fft_sample_loader dut (
    .Clk          (Clk),
    .reset        (reset),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .fft_done     (fft_done),
    .addr         (addr),
    .din_re       (din_re),
    .din_im       (din_im),
    .write_enable (write_enable),
    .frame_ready  (frame_ready),
    .overrun      (overrun),
    .sample_count (sample_count)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (write_enable === 1'b1) begin
      wr_q.push_back('{a: addr, re: din_re, im: din_im});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] tb_bitrev(input int v);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[9-i] = v[i];
    return r;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Valid for one cycle; returns #1 into the following (write) cycle.
  task automatic strobe(input logic [11:0] v);
    @(posedge Clk); #1;
    sample_valid = 1'b1;
    sample_in    = v;
    @(posedge Clk); #1;
    sample_valid = 1'b0;
  endtask

  initial begin
    int bad_a, bad_re, bad_im, sz;

    // Reset values
    cycles(3);
    @(negedge Clk);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_din_re", 32'(din_re), 0);
    chk("rst_din_im", 32'(din_im), 0);
    chk("rst_we", 32'(write_enable), 0);
    chk("rst_ready", 32'(frame_ready), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_count", 32'(sample_count), 0);

    // Full frame, sample_in = index
    reset = 1'b0;
    enable = 1'b1;
    cycles(2);
    wr_q.delete();
    for (int i = 0; i < 1024; i++) begin
      strobe(12'(i));
      cycles(2);
    end
    for (int t = 0; t < 20 && frame_ready !== 1'b1; t++) @(negedge Clk);
    @(negedge Clk);
    chk("frame_ready", 32'(frame_ready), 1);
    chk("frame_count", 32'(sample_count), 1024);
    chk("frame_writes", 32'(wr_q.size()), 1024);
    bad_a = 0; bad_re = 0; bad_im = 0;
    foreach (wr_q[i]) begin
      if (wr_q[i].a !== tb_bitrev(i)) bad_a++;
      if (wr_q[i].re !== 18'(i)) bad_re++;
      if (wr_q[i].im !== 18'h0) bad_im++;
    end
    chk("frame_addr_errs", 32'(bad_a), 0);
    chk("frame_data_errs", 32'(bad_re), 0);
    chk("frame_im_errs", 32'(bad_im), 0);
    if (wr_q.size() >= 4) begin
      chk("addr_s1", 32'(wr_q[1].a), 32'd512);
      chk("addr_s3", 32'(wr_q[3].a), 32'd768);
    end else begin
      chk("frame_short", 32'(wr_q.size()), 4);
    end
    chk("overrun_clean", 32'(overrun), 0);

    // Strobe while READY: dropped, overrun set
    wr_q.delete();
    strobe(12'h123);
    cycles(2);
    @(negedge Clk);
    chk("ready_no_write", 32'(wr_q.size()), 0);
    chk("ready_overrun", 32'(overrun), 1);
    chk("ready_hold", 32'(frame_ready), 1);

    // fft_done starts a new frame
    @(posedge Clk); #1;
    fft_done = 1'b1;
    @(posedge Clk); #1;
    fft_done = 1'b0;
    @(negedge Clk);
    chk("done_ready", 32'(frame_ready), 0);
    chk("done_addr", 32'(addr), 0);
    chk("done_count", 32'(sample_count), 0);
    chk("done_overrun", 32'(overrun), 1);

    // Sign extension
    strobe(12'h800);
    @(negedge Clk);
    chk("sx_neg_we", 32'(write_enable), 1);
    chk("sx_neg_addr", 32'(addr), 0);
    chk("sx_neg_data", 32'(din_re), 32'h3F800);
    chk("sx_neg_im", 32'(din_im), 0);
    cycles(1);
    strobe(12'h7FF);
    @(negedge Clk);
    chk("sx_pos_addr", 32'(addr), 32'd512);
    chk("sx_pos_data", 32'(din_re), 32'h007FF);

    // fft_done outside READY is ignored
    @(posedge Clk); #1;
    fft_done = 1'b1;
    @(posedge Clk); #1;
    fft_done = 1'b0;
    @(negedge Clk);
    chk("fill_done_ign_ready", 32'(frame_ready), 0);
    chk("fill_done_ign_count", 32'(sample_count), 2);

    // Reset after 300 samples
    for (int i = 2; i < 300; i++) strobe(12'(i));
    chk("pre_rst_count", 32'(sample_count), 300);
    reset = 1'b1;
    enable = 1'b0;
    @(posedge Clk); #1;
    sz = wr_q.size();
    @(negedge Clk);
    chk("mid_rst_we", 32'(write_enable), 0);
    chk("mid_rst_addr", 32'(addr), 0);
    chk("mid_rst_din", 32'(din_re), 0);
    chk("mid_rst_count", 32'(sample_count), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    cycles(2);
    chk("mid_rst_no_write", 32'(wr_q.size()), 32'(sz));

    // Re-enable; back-to-back strobes: first written at addr 0, second dropped
    reset = 1'b0;
    cycles(1);
    enable = 1'b1;
    wr_q.delete();
    @(posedge Clk); #1;
    sample_valid = 1'b1;
    sample_in = 12'd7;
    @(posedge Clk); #1;
    sample_in = 12'd8;
    @(negedge Clk);
    chk("b2b_we", 32'(write_enable), 1);
    chk("b2b_addr", 32'(addr), 0);
    chk("b2b_data", 32'(din_re), 7);
    @(posedge Clk); #1;
    sample_valid = 1'b0;
    cycles(2);
    @(negedge Clk);
    chk("b2b_overrun", 32'(overrun), 1);
    chk("b2b_count", 32'(sample_count), 1);
    chk("b2b_writes", 32'(wr_q.size()), 1);
    chk("b2b_next_addr", 32'(addr), 32'd512);

    // Deassert enable during the 10th sample's write cycle
    reset = 1'b1;
    enable = 1'b0;
    cycles(2);
    reset = 1'b0;
    enable = 1'b1;
    cycles(1);
    wr_q.delete();
    for (int i = 0; i < 9; i++) strobe(12'(100 + i));
    @(posedge Clk); #1;
    sample_valid = 1'b1;
    sample_in = 12'hABC;
    @(posedge Clk); #1;
    sample_valid = 1'b0;
    enable = 1'b0;
    @(negedge Clk);
    chk("dis_pending_we", 32'(write_enable), 1);
    chk("dis_pending_data", 32'(din_re), 32'h3FABC);
    cycles(3);
    @(negedge Clk);
    chk("dis_count", 32'(sample_count), 0);
    chk("dis_writes", 32'(wr_q.size()), 10);
    chk("dis_addr", 32'(addr), 0);
    for (int i = 0; i < 3; i++) strobe(12'(i));
    cycles(2);
    @(negedge Clk);
    chk("idle_overrun", 32'(overrun), 0);
    chk("idle_no_write", 32'(wr_q.size()), 10);
    chk("idle_count", 32'(sample_count), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fft_sample_loader.md
Name: fft_sample_loader

Overview:
- Upstream stage of the FFT data RAMs. Collects one frame of 2**RAM_ADDR_BITS ADC samples from the audio front end.
- Writes each sample, sign-extended, into the real-data RAM and writes zero into the imaginary-data RAM. Both writes use bit-reversed addresses, so the in-place FFT reads natural order.
- Raises frame_ready when a frame is complete and holds off the next frame until the FFT engine signals fft_done.

Parameters:
- RAM_WIDTH, 18, data word width of both RAMs.
- RAM_ADDR_BITS, 10, address width; frame length N = 2**RAM_ADDR_BITS.
- SAMPLE_WIDTH, 12, width of the signed two's-complement ADC sample.

Ports:
- Clk  in  1  single system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  arm capture; level-sensitive.
- sample_in  in  SAMPLE_WIDTH  signed ADC sample.
- sample_valid  in  1  one-cycle strobe; sample_in is valid in the same cycle.
- fft_done  in  1  one-cycle pulse from the FFT engine; RAMs may be refilled.
- addr  out  RAM_ADDR_BITS  shared write address to real RAM port A and imag RAM port A.
- din_re  out  RAM_WIDTH  data to the real RAM.
- din_im  out  RAM_WIDTH  data to the imag RAM; always zero.
- write_enable  out  1  write strobe to both RAMs.
- frame_ready  out  1  level; a full frame is resident.
- overrun  out  1  sticky flag; a sample was dropped while capturing.
- sample_count  out  RAM_ADDR_BITS+1  samples written into the current frame.

Behaviour:
- RAM write timing:
  - The RAMs register the address one cycle before the write.
  - The loader drives addr in cycle k, then drives din_re, din_im and write_enable in cycle k+1.
  - addr must not change between those two cycles. Hold addr until the next accepted sample.
- Reset values:
  - All outputs 0.
  - State IDLE, internal counter 0.
  - Reset mid-frame abandons the frame. RAM contents are don't-care and no write is issued after reset.
- States:
  - IDLE:
    - frame_ready=0.
    - When enable=1, go to FILL next cycle, with counter 0 and addr = bitrev(0) = 0.
  - FILL, on sample_valid:
    - Cycle k: latch the sample; addr already equals bitrev(counter).
    - Cycle k+1: write_enable=1, din_re = sign-extend(sample) to RAM_WIDTH, din_im=0.
    - Counter increments in cycle k+1 and sample_count follows it. addr updates to bitrev(counter+1) in cycle k+2.
    - When counter reaches N-1 and its write completes, go to READY. sample_count = N.
  - FILL, on enable deasserted:
    - Finish any pending write, then go to IDLE.
    - Counter and sample_count clear to 0.
  - READY:
    - frame_ready=1, no writes.
    - On fft_done: frame_ready drops next cycle, counter clears, and the state goes to FILL if enable=1, else IDLE.
- Sample acceptance:
  - Maximum one sample per two cycles. sample_valid in the cycle immediately after an accepted strobe is dropped and sets overrun.
  - sample_valid in READY is dropped and sets overrun.
  - sample_valid in IDLE is ignored and does not set overrun.
  - overrun clears only on reset.
- Simultaneous events:
  - fft_done outside READY is ignored.
  - sample_valid in the same cycle fft_done is accepted in READY is dropped and sets overrun.
- Width rules:
  - Bit reversal: addr[i] = counter[RAM_ADDR_BITS-1-i].
  - Sign extension replicates sample_in[SAMPLE_WIDTH-1]. SAMPLE_WIDTH must be <= RAM_WIDTH.
  - Counter wraps only through the state transitions; it never wraps silently.

Decomposition:
- Shared package spec_pkg holds:
  - RAM_WIDTH and RAM_ADDR_BITS, the defaults common to the data RAMs and the FFT engine;
  - the loader state encoding (IDLE=2'd0, FILL=2'd1, READY=2'd2);
  - a bit-reverse function.
- No sub-module is required. An optional combinational helper bit_reverse may be instantiated for reuse by the FFT address generator.

Test Plan:
- Reset, then enable=1, then 1024 strobes every 4 cycles with sample_in=index:
  - writes land at bit-reversed addresses, e.g. sample 1 -> addr 512, sample 3 -> addr 768;
  - the last write is followed by frame_ready=1 and sample_count=1024;
  - din_im=0 on every write.
- sample_in=12'h800 -> din_re=18'h3F800; sample_in=12'h7FF -> din_re=18'h007FF.
- While in READY, strobe sample_valid -> no write_enable and overrun=1. Then pulse fft_done -> frame_ready drops, a new frame starts at addr 0, and overrun stays 1.
- Strobes on consecutive cycles in FILL -> the first is written, the second is dropped, overrun=1, and sample_count advances by 1.
- Assert reset after 300 samples -> all outputs 0 next cycle and no write_enable. Re-enable -> the first write goes to addr 0.
- Deassert enable after 10 samples -> the pending write completes, the state returns to IDLE and sample_count=0. Strobes while in IDLE do not set overrun.
